// File: rtl/ss_pkg.sv
// Shared definitions for the source_sink stream path: default sizing and word/count types.
package ss_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CW    = $clog2(DEFAULT_DEPTH) + 1;

    typedef logic [DEFAULT_WIDTH-1:0] ss_word_t;
    typedef logic [DEFAULT_CW-1:0]    ss_cnt_t;

endpackage

// File: rtl/ss_fifo_if.sv
// Valid/ready stream bundle carrying both the ingress and egress handshakes of the buffer.
interface ss_fifo_if
    import ss_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // The side that feeds words in and drains them out.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The buffer itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/ss_fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one asynchronous read port.
module ss_fifo_mem
    import ss_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk1,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left unreset; the pointers decide what is valid.
    always_ff @(posedge clk1) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ss_fifo.sv
// Elastic valid/ready buffer with occupancy and high-watermark tracking.
module ss_fifo
    import ss_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk1,
    input  logic          rst,
    ss_fifo_if.slave      bus,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] hwm
);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_data;
    logic             push;
    logic             pop;

    // Flags come only from registered occupancy, so no input reaches an output combinationally.
    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = bus.out_valid ? head_data : '0;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointer, occupancy and watermark registers; reset drops everything in flight.
    always_ff @(posedge clk1) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hwm    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            if (count_next > hwm) begin
                hwm <= count_next;
            end
        end
    end

    ss_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk1  (clk1),
        .we    (push && rst),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (head_data)
    );

endmodule

// File: tb/tb_ss_fifo.sv
// Directed self-checking bench for ss_fifo (WIDTH=8, DEPTH=4).
module tb_ss_fifo;
    import ss_pkg::*;

    logic    clk1;
    logic    rst;
    ss_cnt_t count;
    ss_cnt_t hwm;
    logic    full;
    logic    empty;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ss_fifo_if #(.WIDTH(8)) bus ();

    ss_fifo #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk1  (clk1),
        .rst   (rst),
        .bus   (bus),
        .count (count),
        .full  (full),
        .empty (empty),
        .hwm   (hwm)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    // Advance past the next rising edge so outputs are settled when sampled.
    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic reset_dut();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.out_ready = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        repeat (3) step();
        total_cnt++; if (count !== 3'd0) $display("[TB] FAIL reset_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty got %b want 1", empty); else pass_cnt++;
        total_cnt++; if (full !== 1'b0) $display("[TB] FAIL reset_full got %b want 0", full); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_data !== 8'h00) $display("[TB] FAIL reset_out_data got %h want 00", bus.out_data); else pass_cnt++;
        total_cnt++; if (hwm !== 3'd0) $display("[TB] FAIL reset_hwm got %0d want 0", hwm); else pass_cnt++;
    endtask

    task automatic test_single();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        step();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL single_out_valid got %b want 1", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_data !== 8'h11) $display("[TB] FAIL single_out_data got %h want 11", bus.out_data); else pass_cnt++;
        total_cnt++; if (count !== 3'd1) $display("[TB] FAIL single_count got %0d want 1", count); else pass_cnt++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total_cnt++; if (count !== 3'd0) $display("[TB] FAIL single_drain_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL single_drain_empty got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_burst();
        logic [7:0] rx [8];
        int         nrx;
        logic       ready_at_first_pop;
        logic       a4_pushed;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA0 + 8'(i);
            step();
        end
        bus.in_data = 8'hA4;
        total_cnt++; if (full !== 1'b1) $display("[TB] FAIL burst_full got %b want 1", full); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL burst_in_ready got %b want 0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (count !== 3'd4) $display("[TB] FAIL burst_count got %0d want 4", count); else pass_cnt++;
        total_cnt++; if (hwm !== 3'd4) $display("[TB] FAIL burst_hwm got %0d want 4", hwm); else pass_cnt++;
        step();
        total_cnt++; if (count !== 3'd4) $display("[TB] FAIL burst_blocked_count got %0d want 4", count); else pass_cnt++;
        total_cnt++; if (bus.out_data !== 8'hA0) $display("[TB] FAIL burst_head got %h want a0", bus.out_data); else pass_cnt++;
        bus.out_ready      = 1'b1;
        nrx                = 0;
        ready_at_first_pop = 1'bx;
        a4_pushed          = 1'b0;
        for (int c = 0; c < 20 && nrx < 5; c++) begin
            if (bus.out_valid) begin
                if (nrx == 0) ready_at_first_pop = bus.in_ready;
                rx[nrx] = bus.out_data;
                nrx++;
            end
            if (bus.in_valid && bus.in_ready) a4_pushed = 1'b1;
            step();
            if (a4_pushed) bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total_cnt++; if (ready_at_first_pop !== 1'b0) $display("[TB] FAIL burst_push_on_first_pop got %b want 0", ready_at_first_pop); else pass_cnt++;
        total_cnt++; if (nrx !== 5) $display("[TB] FAIL burst_rx_count got %0d want 5", nrx); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (i >= nrx) $display("[TB] FAIL burst_rx%0d got none want %h", i, 8'hA0 + 8'(i));
            else if (rx[i] !== 8'hA0 + 8'(i)) $display("[TB] FAIL burst_rx%0d got %h want %h", i, rx[i], 8'hA0 + 8'(i));
            else pass_cnt++;
        end
        total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL burst_final_empty got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [7:0] rx [12];
        int         nrx;
        int         bad_count;
        reset_dut();
        nrx       = 0;
        bad_count = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            bus.in_valid = (c < 10);
            bus.in_data  = 8'(c);
            if (bus.out_valid) begin
                rx[nrx] = bus.out_data;
                nrx++;
            end
            step();
            if (c < 10 && count !== 3'd1) bad_count++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total_cnt++; if (bad_count !== 0) $display("[TB] FAIL stream_count_steady got %0d bad cycles want 0", bad_count); else pass_cnt++;
        total_cnt++; if (nrx !== 10) $display("[TB] FAIL stream_rx_count got %0d want 10", nrx); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            total_cnt++;
            if (i >= nrx) $display("[TB] FAIL stream_rx%0d got none want %h", i, 8'(i));
            else if (rx[i] !== 8'(i)) $display("[TB] FAIL stream_rx%0d got %h want %h", i, rx[i], 8'(i));
            else pass_cnt++;
        end
        total_cnt++; if (hwm !== 3'd1) $display("[TB] FAIL stream_hwm got %0d want 1", hwm); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("[TB] FAIL stream_final_count got %0d want 0", count); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_q [3];
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h30 + 8'(i);
            step();
        end
        bus.in_data   = 8'h33;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total_cnt++; if (count !== 3'd3) $display("[TB] FAIL simul_count got %0d want 3", count); else pass_cnt++;
        total_cnt++; if (bus.out_data !== 8'h31) $display("[TB] FAIL simul_head got %h want 31", bus.out_data); else pass_cnt++;
        exp_q[0] = 8'h31;
        exp_q[1] = 8'h32;
        exp_q[2] = 8'h33;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[i])
                $display("[TB] FAIL simul_drain%0d got valid=%b data=%h want valid=1 data=%h", i, bus.out_valid, bus.out_data, exp_q[i]);
            else pass_cnt++;
            step();
        end
        bus.out_ready = 1'b0;
        total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL simul_final_empty got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h50 + 8'(i);
            step();
        end
        total_cnt++; if (count !== 3'd2) $display("[TB] FAIL midrst_fill_count got %0d want 2", count); else pass_cnt++;
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h52;
        bus.out_ready = 1'b1;
        step();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total_cnt++; if (count !== 3'd0) $display("[TB] FAIL midrst_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (hwm !== 3'd0) $display("[TB] FAIL midrst_hwm got %0d want 0", hwm); else pass_cnt++;
        total_cnt++; if (bus.out_data !== 8'h00) $display("[TB] FAIL midrst_out_data got %h want 00", bus.out_data); else pass_cnt++;
        step();
        total_cnt++; if (count !== 3'd0) $display("[TB] FAIL midrst_discard_count got %0d want 0", count); else pass_cnt++;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h60;
        step();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_data !== 8'h60) $display("[TB] FAIL midrst_repush_head got %h want 60", bus.out_data); else pass_cnt++;
        total_cnt++; if (hwm !== 3'd1) $display("[TB] FAIL midrst_repush_hwm got %0d want 1", hwm); else pass_cnt++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_stream();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
